// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
// Holds the FSM state encoding and the default operand width.
package seq_divider_pkg;

    // Default operand/result width in bits.
    localparam int unsigned DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider.
//   start     : request a division (honoured only while idle)
//   dvd, dvs  : unsigned dividend / divisor, captured on an accepted start
//   busy      : iteration phase in progress
//   done      : one-cycle pulse, quo/rem valid from this cycle
//   quo, rem  : quotient / remainder
//   err       : divide-by-zero flag
// master drives the request, slave (the divider) drives the results.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int unsigned W = DIV_W
);
    logic         start;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         err;

    modport master (
        output start, dvd, dvs,
        input  busy, done, quo, rem, err
    );

    modport slave (
        input  start, dvd, dvs,
        output busy, done, quo, rem, err
    );
endinterface

// File: rtl/seq_divider_shl_reg.sv
// Quotient/dividend register of the divider.
// W-bit register with synchronous parallel load and left shift; the serial
// input enters bit 0. Load wins over shift.
//   clk   : rising-edge clock
//   clr   : asynchronous active-high clear
//   load  : load din
//   shift : shift left, sin into bit 0
//   sin   : serial input
//   din   : parallel load data
//   q     : register contents
module shl_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset
//   bus : seq_divider_if slave (start/dvd/dvs in, busy/done/quo/rem/err out)
// Optional feature: define SEQ_DIVIDER_DIVZERO_EN to short-cut dvs=0 straight
// to DONE with err=1, quo=0, rem=dvd. Without it err is tied 0 and dvs=0 runs
// the normal iterations (quo all ones, rem=dvd).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input logic          clk,
    input logic          clr,
    seq_divider_if.slave bus
);
    localparam int unsigned   CW   = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W:0]    a;        // partial remainder
    logic [W-1:0]  dvs_r;
    logic [W-1:0]  q;
    logic [W-1:0]  q_din;
    logic [CW-1:0] cnt;
    logic          busy_r;
    logic          done_r;
    logic          accept;
    logic          shift_en;
    logic          dz;
    logic [W:0]    a_sh;
    logic [W:0]    diff;
    logic          qbit;

`ifdef SEQ_DIVIDER_DIVZERO_EN
    logic err_r;
    assign dz      = (bus.dvs == '0);
    assign bus.err = err_r;
`else
    assign dz      = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign accept   = (state == IDLE) && bus.start;
    assign shift_en = (state == RUN);

    // {A,Q} shifted left by one; A's old MSB falls off (it is always 0 after
    // a restore since A < divisor).
    assign a_sh = (W + 1)'({a, q[W-1]});
    assign diff = a_sh - {1'b0, dvs_r};
    assign qbit = ~diff[W];
    assign q_din = dz ? '0 : bus.dvd;

    shl_reg #(
        .W (W)
    ) u_q (
        .clk   (clk),
        .clr   (clr),
        .load  (accept),
        .shift (shift_en),
        .sin   (qbit),
        .din   (q_din),
        .q     (q)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            a      <= '0;
            dvs_r  <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
            err_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvs_r <= bus.dvs;
                        cnt   <= '0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
                        err_r <= dz;
`endif
                        if (dz) begin
                            a      <= {1'b0, bus.dvd};
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            a      <= '0;
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    a   <= qbit ? diff : a_sh;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.quo  = q;
    assign bus.rem  = a[W-1:0];
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized
// divisions compared against plain integer division.
module tb_seq_divider;
    localparam int unsigned W = 4;

    logic clk;
    logic clr;
    int   errors = 0;
    int   checks = 0;
    int   last_q = 0;
    int   last_r = 0;

    seq_divider_if #(.W(W)) bus ();

    seq_divider #(
        .W (W)
    ) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, plus the zero-divisor rules.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int e, output int lat);
        lat = W + 1;
        e   = 0;
        if (b == 0) begin
            r = a;
`ifdef SEQ_DIVIDER_DIVZERO_EN
            q   = 0;
            e   = 1;
            lat = 1;
`else
            q = (1 << W) - 1;
`endif
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called just after a negedge with the block idle. mode 0: random noise on
    // start/operands while busy; 1: start=1 with na/nb through RUN and DONE;
    // 2: as 1 but start stays high into the following IDLE cycle.
    task automatic do_div(input int a, input int b, input int mode, input int na, input int nb);
        int eq, er, ee, lat;
        model(a, b, eq, er, ee, lat);
        bus.start = 1'b1;
        bus.dvd   = W'(a);
        bus.dvs   = W'(b);
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check("busy", int'(bus.busy), int'(k < lat));
            check("done", int'(bus.done), int'(k == lat));
            if (k >= lat) begin
                check("quo", int'(bus.quo), eq);
                check("rem", int'(bus.rem), er);
                check("err", int'(bus.err), ee);
                last_q = eq;
                last_r = er;
            end
            if (mode == 2 || (mode == 1 && k <= lat)) begin
                bus.start = 1'b1;
                bus.dvd   = W'(na);
                bus.dvs   = W'(nb);
            end else if (mode == 0 && k <= lat) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.dvd   = W'($urandom);
                bus.dvs   = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        int a, b;
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err",  int'(bus.err), 0);
        check("rst_quo",  int'(bus.quo), 0);
        check("rst_rem",  int'(bus.rem), 0);
        clr = 1'b0;
        @(negedge clk);

        do_div(13, 3, 0, 0, 0);
        do_div(15, 1, 0, 0, 0);
        do_div(2, 7, 0, 0, 0);
        // Results must hold while idle regardless of operand changes.
        for (int i = 0; i < 5; i++) begin
            bus.dvd = W'($urandom);
            bus.dvs = W'($urandom);
            @(negedge clk);
            check("hold_quo", int'(bus.quo), last_q);
            check("hold_rem", int'(bus.rem), last_r);
        end
        do_div(9, 0, 0, 0, 0);
        do_div(9, 2, 0, 0, 0);

        // Abort in the 2nd RUN cycle.
        bus.start = 1'b1;
        bus.dvd   = W'(12);
        bus.dvs   = W'(5);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1 clr = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_err",  int'(bus.err), 0);
        check("abort_quo",  int'(bus.quo), 0);
        check("abort_rem",  int'(bus.rem), 0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("abort_nodone", int'(bus.done), 0);
        end
        do_div(12, 5, 0, 0, 0);

        // New requests during RUN/DONE are ignored.
        do_div(6, 4, 1, 7, 2);
        @(negedge clk);
        check("ignored_idle", int'(bus.busy), 0);
        // Start held high: the next division begins straight after DONE.
        do_div(6, 4, 2, 7, 2);
        do_div(7, 2, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
            do_div(a, b, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
